pulse_burst_gen: RTL and testbench
==================================

# pulse_burst_gen

Generates a burst of N clean, fixed-width pulses on a single output line, where N is a 4-bit value latched at start. It is the transmit-side counterpart of the debounced button counter: it turns a count back into a pulse train. Its `pulse` output can drive a debounced counter input directly, so it serves as an on-board self-test stimulus and a programmable event source. It sits between control logic, which issues `start`/`count`, and any pulse-consuming block.

## Interface
- `HIGH_CYCLES`, default 4: clock cycles `pulse` stays high per pulse. Must be ≥1. In system use, set it above the debounce filter window.
- `LOW_CYCLES`, default 4: clock cycles `pulse` stays low after each pulse. Must be ≥1.
- `clock` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request, sampled only in IDLE.
- `count` input 4: number of pulses to emit, sampled with `start`.
- `abort` input 1: synchronous cancel of the burst in progress.
- `pulse` output 1: generated pulse train (registered).
- `busy` output 1: high while a burst is in progress (registered).
- `done` output 1: one-cycle strobe when a burst completes normally (registered).
- `remaining` output 4: pulses not yet completed (registered).

## Operation
- Reset takes effect at the rising edge where `reset`=1. It overrides every other input.
  - State becomes IDLE.
  - `pulse`=0, `busy`=0, `done`=0, `remaining`=0, phase timer=0.
- States are IDLE, HIGH and LOW.
- IDLE:
  - `start`=1 and `count`≠0: latch `remaining`=`count`, load timer, go to HIGH.
  - `start`=1 and `count`=0: stay in IDLE, assert `done` for the next single cycle, never raise `pulse`.
  - `start`=0: hold.
- HIGH: `pulse`=1 for exactly HIGH_CYCLES cycles. Then go to LOW; `remaining` decrements by 1 on that transition.
- LOW: `pulse`=0 for exactly LOW_CYCLES cycles. Then:
  - `remaining`=0: go to IDLE and assert `done` for one cycle.
  - otherwise: go to HIGH.
- `busy`=1 exactly when the state is HIGH or LOW.
- `done` is high only in the first IDLE cycle after a normal completion, or after a `count`=0 start. Otherwise it is 0.
- `start` is ignored while `busy`=1; there is no queueing.
- A `start` in the same cycle `done`=1 is accepted, because the block is in IDLE.
- `abort`=1 while busy: next cycle go to IDLE with `pulse`=0, `busy`=0, `remaining`=0 and `done`=0. `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, `abort` wins and `start` is dropped.
- The timer width is the bit width needed for max(HIGH_CYCLES, LOW_CYCLES)−1. There is no wrap; the timer reloads on each phase entry.
- `remaining` never underflows: it decrements only on a HIGH→LOW transition, and it is ≥1 in HIGH.

## Timing
- `start` is sampled at edge E. The first `pulse`=1 cycle, k, is the cycle following E.
- With N=`count`, H=HIGH_CYCLES, L=LOW_CYCLES, for pulse i (0…N−1):
  - `pulse`=1 in cycles k+i(H+L) through k+i(H+L)+H−1.
  - `pulse`=0 for the following L cycles.
- `busy`=1 in cycles k through k+N(H+L)−1.
- `done`=1 in cycle k+N(H+L) only; `busy`=0 in that cycle.
- `remaining`=N−i during pulse i's high phase and N−i−1 during its low phase. It is 0 throughout the final low phase.
- Back-to-back bursts: the earliest next `start` is sampled in the `done` cycle, giving a 1-cycle idle gap, so the minimum low time between the last and first pulse is L+1.
- `count`=0 start: `done`=1 in cycle k, `busy` stays 0.
- Abort: `abort` is sampled at edge A. In the cycle after A: `pulse`=0, `busy`=0, `remaining`=0.
- Reset mid-burst: the same cycle-after response as abort, and `done` stays 0.

## Test plan
- Reset: hold `reset` 2 cycles with `start`=1 and `count`=5 → `pulse`/`busy`/`done`/`remaining` all 0 throughout; no burst afterwards.
- Nominal burst with H=4, L=4, `count`=3:
  - Exactly 3 pulses, each 4 cycles high, 4 low.
  - `busy` high for 24 cycles.
  - `done`=1 at cycle k+24 for one cycle.
  - `remaining` reads 3,2,2,1,1,0 per phase.
- Zero count: `start` with `count`=0 → `done`=1 for 1 cycle on the next cycle; `pulse` and `busy` never go high.
- Ignored start: burst of 2 running; pulse `start` with `count`=7 mid-burst → still exactly 2 pulses, `done` at k+16, no extra pulses.
- Abort and restart:
  - `count`=4, assert `abort` during the second high phase → next cycle `pulse`=0, `busy`=0, `remaining`=0, `done` never asserted.
  - A subsequent `start` with `count`=1 → one normal pulse, then `done`.
- Max and back-to-back:
  - `count`=15 → 15 pulses, `busy` 120 cycles.
  - `start` with `count`=1 issued in the `done` cycle → new pulse begins the next cycle; low gap between bursts = 5 cycles.

Source files
------------

// File: rtl/pulse_burst_gen_if.sv
// pulse_burst_gen_if: control/status bundle between a burst requester and the pulse generator
interface pulse_burst_gen_if;
  logic start;
  logic [3:0] count;
  logic abort;
  logic pulse;
  logic busy;
  logic done;
  logic [3:0] remaining;
  modport master(output start, count, abort, input pulse, busy, done, remaining);
  modport slave(input start, count, abort, output pulse, busy, done, remaining);
endinterface

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: emits a burst of count fixed-width pulses (HIGH_CYCLES high, LOW_CYCLES low)
module pulse_burst_gen #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES = 4
) (
  input logic clock,
  input logic reset,
  pulse_burst_gen_if.slave bus
);
  localparam int MX = HIGH_CYCLES > LOW_CYCLES ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW = MX > 1 ? $clog2(MX) : 1;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0] rem, rem_n;
  logic done, done_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      rem <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      rem <= rem_n;
      done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    timer_n = timer - 1'b1;
    rem_n = rem;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (bus.start && !bus.abort) begin
          if (bus.count != 4'd0) begin
            state_n = HIGH;
            timer_n = TW'(HIGH_CYCLES - 1);
            rem_n = bus.count;
          end else done_n = 1'b1;
        end
      end
      HIGH:
        if (timer == '0) begin
          state_n = LOW;
          timer_n = TW'(LOW_CYCLES - 1);
          rem_n = rem - 4'd1;
        end
      LOW:
        if (timer == '0) begin
          state_n = rem == 4'd0 ? IDLE : HIGH;
          timer_n = rem == 4'd0 ? '0 : TW'(HIGH_CYCLES - 1);
          done_n = rem == 4'd0;
        end
      default: state_n = IDLE;
    endcase
    // abort only cancels a running burst; in IDLE it merely blocks start above
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      timer_n = '0;
      rem_n = '0;
      done_n = 1'b0;
    end
  end
  always_comb begin
    bus.pulse = state == HIGH;
    bus.busy = state != IDLE;
    bus.done = done;
    bus.remaining = rem;
  end
endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb_pulse_burst_gen: scoreboard bench comparing every cycle against a per-burst trace model
module tb_pulse_burst_gen;
  localparam int H = 4;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst;
  pulse_burst_gen_if bus();
  pulse_burst_gen #(.HIGH_CYCLES(H), .LOW_CYCLES(L)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] exp_q[$];
  logic [6:0] fut[$];
  logic [6:0] cur = '0;
  int checks = 0;
  int passes = 0;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [6:0] e;
      logic [6:0] a;
      e = exp_q.pop_front();
      a = {bus.pulse, bus.busy, bus.done, bus.remaining};
      checks++;
      if (a === e) passes++;
      else $display("FAIL cycle_out t=%0t got pulse/busy/done/rem=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                    $time, a[6], a[5], a[4], a[3:0], e[6], e[5], e[4], e[3:0]);
    end
  end
  task automatic burst(input logic [3:0] n);
    fut.delete();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < H; j++) fut.push_back({3'b110, 4'(n - i)});
      for (int j = 0; j < L; j++) fut.push_back({3'b010, 4'(n - i - 1)});
    end
    fut.push_back({3'b001, 4'd0});
  endtask
  task automatic step(input bit s, input logic [3:0] c, input bit a, input bit r);
    logic [6:0] nxt;
    bus.start = s;
    bus.count = c;
    bus.abort = a;
    rst = r;
    if (r || (cur[5] && a)) begin
      fut.delete();
      nxt = '0;
    end else if (!cur[5] && s && !a) begin
      burst(c);
      nxt = fut.pop_front();
    end else nxt = fut.size() != 0 ? fut.pop_front() : 7'd0;
    exp_q.push_back(nxt);
    cur = nxt;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0);
  endtask
  task automatic until_done();
    for (int i = 0; i < 300 && !cur[4]; i++) step(0, 4'd0, 0, 0);
    checks++;
    if (cur[4] && bus.done === 1'b1) passes++;
    else $display("FAIL until_done t=%0t wait expired without done (model=%b dut=%b)", $time, cur[4], bus.done);
  endtask
  initial begin
    step(1, 4'd5, 0, 1);
    step(1, 4'd5, 0, 1);
    checks++;
    if ({bus.pulse, bus.busy, bus.done, bus.remaining} === 7'd0) passes++;
    else $display("FAIL reset_state t=%0t pulse/busy/done/rem=%b/%b/%b/%0d", $time,
                  bus.pulse, bus.busy, bus.done, bus.remaining);
    idle(4);
    step(1, 4'd3, 0, 0);
    until_done();
    idle(2);
    step(1, 4'd0, 0, 0);
    idle(3);
    step(1, 4'd2, 0, 0);
    idle(5);
    step(1, 4'd7, 0, 0);
    until_done();
    idle(2);
    step(1, 4'd4, 0, 0);
    idle(9);
    step(0, 4'd0, 1, 0);
    idle(3);
    step(1, 4'd1, 0, 0);
    until_done();
    idle(2);
    step(1, 4'd6, 1, 0);
    idle(2);
    step(1, 4'd15, 0, 0);
    until_done();
    step(1, 4'd1, 0, 0);
    until_done();
    step(1, 4'd2, 0, 0);
    idle(6);
    step(0, 4'd0, 0, 1);
    idle(3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 79) == 0, $urandom_range(0, 599) == 0);
    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
